// File: rtl/baccarat_match_fsm.sv
// baccarat_match_fsm: sequences card loads, third-card draws, hand results and
// match tallies for a multi-hand baccarat match.
module baccarat_match_fsm #(
    parameter int ROUNDS      = 5,
    parameter int CNT_W       = 4,
    parameter int HOLD_CYCLES = 2
) (
    input  logic             slow_clock,
    input  logic             resetb,
    input  logic             start,
    input  logic [3:0]       pscore,
    input  logic [3:0]       dscore,
    input  logic [3:0]       pcard3,
    output logic             load_pcard1,
    output logic             load_pcard2,
    output logic             load_pcard3,
    output logic             load_dcard1,
    output logic             load_dcard2,
    output logic             load_dcard3,
    output logic             clear_hand,
    output logic             player_win_light,
    output logic             dealer_win_light,
    output logic [CNT_W-1:0] player_wins,
    output logic [CNT_W-1:0] dealer_wins,
    output logic [CNT_W-1:0] ties,
    output logic [CNT_W-1:0] hand_num,
    output logic             busy,
    output logic             match_done
);
    localparam int HW = $clog2(HOLD_CYCLES + 1);

    typedef enum logic [3:0] {
        IDLE, P1, D1, P2, D2, EVAL, P3, D3DEC, D3, RESULT, HOLD, CLEAR, DONE
    } state_t;

    state_t        state;
    logic          p_flag;
    logic          d_flag;
    logic [HW-1:0] hold_cnt;
    logic          d3_draw;

    // Banker's third-card table, keyed on the banker score and the player's third card
    always_comb
        d3_draw = (dscore <= 4'd2) ||
                  (dscore == 4'd3 && pcard3 != 4'd8) ||
                  (dscore == 4'd4 && pcard3 >= 4'd2 && pcard3 <= 4'd7) ||
                  (dscore == 4'd5 && pcard3 >= 4'd4 && pcard3 <= 4'd7) ||
                  (dscore == 4'd6 && pcard3 >= 4'd6 && pcard3 <= 4'd7);

    always_ff @(posedge slow_clock or negedge resetb) begin
        if (!resetb) begin
            state       <= IDLE;
            p_flag      <= 1'b0;
            d_flag      <= 1'b0;
            hold_cnt    <= '0;
            player_wins <= '0;
            dealer_wins <= '0;
            ties        <= '0;
            hand_num    <= '0;
        end else begin
            case (state)
                IDLE, DONE: if (start) begin
                    state       <= P1;
                    p_flag      <= 1'b0;
                    d_flag      <= 1'b0;
                    player_wins <= '0;
                    dealer_wins <= '0;
                    ties        <= '0;
                    hand_num    <= '0;
                end
                P1:     state <= D1;
                D1:     state <= P2;
                P2:     state <= D2;
                D2:     state <= EVAL;
                EVAL:   state <= (pscore >= 4'd8 || dscore >= 4'd8) ? RESULT :
                                 (pscore <= 4'd5) ? P3 :
                                 (dscore <= 4'd5) ? D3 : RESULT;
                P3:     state <= D3DEC;
                D3DEC:  state <= d3_draw ? D3 : RESULT;
                D3:     state <= RESULT;
                RESULT: begin
                    p_flag      <= pscore >= dscore;
                    d_flag      <= dscore >= pscore;
                    player_wins <= player_wins + CNT_W'(pscore > dscore);
                    dealer_wins <= dealer_wins + CNT_W'(dscore > pscore);
                    ties        <= ties + CNT_W'(pscore == dscore);
                    hold_cnt    <= '0;
                    state       <= HOLD;
                end
                HOLD: begin
                    hold_cnt <= hold_cnt + 1'b1;
                    state    <= (hold_cnt == HW'(HOLD_CYCLES - 1)) ? CLEAR : HOLD;
                end
                CLEAR: begin
                    hand_num <= hand_num + 1'b1;
                    state    <= (hand_num + 1'b1 == CNT_W'(ROUNDS)) ? DONE : P1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign load_pcard1      = state == P1;
    assign load_dcard1      = state == D1;
    assign load_pcard2      = state == P2;
    assign load_dcard2      = state == D2;
    assign load_pcard3      = state == P3;
    assign load_dcard3      = state == D3;
    assign clear_hand       = state == CLEAR;
    assign busy             = state != IDLE && state != DONE;
    assign match_done       = state == DONE;
    // Lights show the hand result while holding and the match result once done
    assign player_win_light = (state == HOLD && p_flag) || (state == DONE && player_wins >= dealer_wins);
    assign dealer_win_light = (state == HOLD && d_flag) || (state == DONE && dealer_wins >= player_wins);
endmodule

// File: tb/tb_baccarat_match_fsm.sv
// tb_baccarat_match_fsm: directed and random matches checked against a
// rule-level baccarat model.
module tb_baccarat_match_fsm;
    localparam int ROUNDS = 3;
    localparam int CNT_W  = 4;
    localparam int HOLD   = 3;

    logic             slow_clock = 1'b0;
    logic             resetb     = 1'b0;
    logic             start      = 1'b0;
    logic [3:0]       pscore     = '0;
    logic [3:0]       dscore     = '0;
    logic [3:0]       pcard3     = '0;
    logic             load_pcard1, load_pcard2, load_pcard3;
    logic             load_dcard1, load_dcard2, load_dcard3;
    logic             clear_hand, player_win_light, dealer_win_light, busy, match_done;
    logic [CNT_W-1:0] player_wins, dealer_wins, ties, hand_num;

    int n_checks = 0;
    int n_errors = 0;
    int exp_pw, exp_dw, exp_ti;

    baccarat_match_fsm #(.ROUNDS(ROUNDS), .CNT_W(CNT_W), .HOLD_CYCLES(HOLD)) dut (
        .slow_clock(slow_clock), .resetb(resetb), .start(start),
        .pscore(pscore), .dscore(dscore), .pcard3(pcard3),
        .load_pcard1(load_pcard1), .load_pcard2(load_pcard2), .load_pcard3(load_pcard3),
        .load_dcard1(load_dcard1), .load_dcard2(load_dcard2), .load_dcard3(load_dcard3),
        .clear_hand(clear_hand), .player_win_light(player_win_light),
        .dealer_win_light(dealer_win_light), .player_wins(player_wins),
        .dealer_wins(dealer_wins), .ties(ties), .hand_num(hand_num),
        .busy(busy), .match_done(match_done)
    );

    always #5 slow_clock = ~slow_clock;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic bit banker_draws(input int d, input int c3);
        case (d)
            0, 1, 2: return 1'b1;
            3:       return c3 != 8;
            4:       return c3 >= 2 && c3 <= 7;
            5:       return c3 >= 4 && c3 <= 7;
            6:       return c3 >= 6 && c3 <= 7;
            default: return 1'b0;
        endcase
    endfunction

    function automatic int all_outputs();
        return int'({load_pcard1, load_pcard2, load_pcard3, load_dcard1, load_dcard2,
                     load_dcard3, clear_hand, player_win_light, dealer_win_light, busy,
                     match_done}) + int'(player_wins) + int'(dealer_wins) + int'(ties) +
               int'(hand_num);
    endfunction

    task automatic start_match(input bit keep);
        start = 1'b1;
        @(negedge slow_clock);
        if (!keep) start = 1'b0;
        check("start_p1", int'(load_pcard1), 1);
        check("start_zero", int'(player_wins) + int'(dealer_wins) + int'(ties) + int'(hand_num), 0);
        exp_pw = 0;
        exp_dw = 0;
        exp_ti = 0;
    endtask

    task automatic run_hand(input int p, input int d, input int c3);
        logic [5:0]  s;
        logic [23:0] order = '0;
        int np3 = 0, nd3 = 0, nclr = 0, nmulti = 0, nidle = 0, npl = 0, ndl = 0;
        bit nat, pd, dd;
        pscore = 4'(p);
        dscore = 4'(d);
        pcard3 = 4'(c3);
        nat = p >= 8 || d >= 8;
        pd  = !nat && p <= 5;
        dd  = !nat && (pd ? banker_draws(d, c3) : d <= 5);
        for (int k = 0; k < 60 && nclr == 0; k++) begin
            s = {load_pcard1, load_dcard1, load_pcard2, load_dcard2, load_pcard3, load_dcard3};
            if (k < 4) order = {order[17:0], s};
            if ($countones(s) > 1) nmulti++;
            np3  += int'(load_pcard3);
            nd3  += int'(load_dcard3);
            nidle += int'(!busy);
            npl  += int'(player_win_light);
            ndl  += int'(dealer_win_light);
            nclr += int'(clear_hand);
            @(negedge slow_clock);
        end
        check("hand_clear", nclr, 1);
        check("strobe_order", int'(order), int'(24'b100000_010000_001000_000100));
        check("multi_strobe", nmulti, 0);
        check("busy_in_hand", nidle, 0);
        check("pcard3_loads", np3, int'(pd));
        check("dcard3_loads", nd3, int'(dd));
        check("player_light", npl, p >= d ? HOLD : 0);
        check("dealer_light", ndl, d >= p ? HOLD : 0);
        exp_pw += int'(p > d);
        exp_dw += int'(d > p);
        exp_ti += int'(p == d);
        check("player_wins", int'(player_wins), exp_pw);
        check("dealer_wins", int'(dealer_wins), exp_dw);
        check("ties", int'(ties), exp_ti);
    endtask

    task automatic end_match();
        for (int r = 0; r < 3; r++) begin
            check("match_done", int'(match_done), 1);
            check("done_busy", int'(busy), 0);
            check("done_hand_num", int'(hand_num), ROUNDS);
            check("done_pw", int'(player_wins), exp_pw);
            check("done_dw", int'(dealer_wins), exp_dw);
            check("done_ties", int'(ties), exp_ti);
            check("done_plight", int'(player_win_light), int'(exp_pw >= exp_dw));
            check("done_dlight", int'(dealer_win_light), int'(exp_dw >= exp_pw));
            @(negedge slow_clock);
        end
    endtask

    task automatic directed_match(input int p[ROUNDS], input int d[ROUNDS], input int c[ROUNDS]);
        start_match(1'b0);
        for (int h = 0; h < ROUNDS; h++) begin
            run_hand(p[h], d[h], c[h]);
            check("hand_num", int'(hand_num), h + 1);
        end
        end_match();
    endtask

    initial begin
        int guard;
        #1;
        check("reset_outputs", all_outputs(), 0);
        @(negedge slow_clock);
        resetb = 1'b1;
        @(negedge slow_clock);
        check("idle_no_start", int'(busy) + int'(match_done), 0);
        directed_match('{8, 4, 4}, '{3, 3, 3}, '{0, 8, 7});
        directed_match('{6, 7, 12}, '{5, 6, 3}, '{0, 0, 0});
        directed_match('{6, 6, 6}, '{6, 6, 6}, '{0, 0, 0});
        for (int m = 0; m < 8; m++) begin
            bit keep = (m == 2);
            start_match(keep);
            for (int h = 0; h < ROUNDS; h++) begin
                int hi = (m == 7) ? 15 : 9;
                run_hand($urandom_range(0, hi), $urandom_range(0, hi), $urandom_range(0, 9));
                check("hand_num", int'(hand_num), h + 1);
                start = 1'b0;
            end
            end_match();
        end
        start_match(1'b0);
        run_hand(9, 2, 0);
        pscore = 4'd4;
        dscore = 4'd3;
        pcard3 = 4'd5;
        guard  = 0;
        while (!load_pcard3 && guard < 20) begin
            @(negedge slow_clock);
            guard++;
        end
        check("reach_p3", int'(load_pcard3), 1);
        #2 resetb = 1'b0;
        #1 check("async_reset", all_outputs(), 0);
        @(negedge slow_clock);
        resetb = 1'b1;
        repeat (3) @(negedge slow_clock);
        check("idle_after_reset", all_outputs(), 0);
        directed_match('{3, 5, 0}, '{1, 9, 0}, '{2, 4, 0});
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/baccarat_match_fsm.md
BACCARAT_MATCH_FSM -- requirements
Module: baccarat_match_fsm

Interface
REQ-001 Parameter ROUNDS, default 5, hands per match; range 1 to 2^CNT_W-1.
REQ-002 Parameter CNT_W, default 4, width of the hand and win counters.
REQ-003 Parameter HOLD_CYCLES, default 2, cycles a hand result is displayed; minimum 1.
REQ-004 slow_clock  in  1  sole clock; all state updates on its rising edge.
REQ-005 resetb  in  1  asynchronous, active-low reset.
REQ-006 start  in  1  begin a match; sampled only in IDLE and DONE.
REQ-007 pscore, dscore  in  4 each  player/dealer hand score (0-9), valid the cycle after any load.
REQ-008 pcard3  in  4  value of player third card, valid the cycle after load_pcard3.
REQ-009 load_pcard1..3, load_dcard1..3  out  1 each  one-cycle card load strobes.
REQ-010 clear_hand  out  1  one-cycle strobe clearing all card registers between hands.
REQ-011 player_win_light, dealer_win_light  out  1 each  result lights.
REQ-012 player_wins, dealer_wins, ties  out  CNT_W each  match tallies.
REQ-013 hand_num  out  CNT_W  hands completed in the current match.
REQ-014 busy  out  1  high in every state except IDLE and DONE.
REQ-015 match_done  out  1  high only in DONE.

Function
REQ-016 States SHALL be IDLE, P1, D1, P2, D2, EVAL, P3, D3DEC, D3, RESULT, HOLD, CLEAR, DONE.
REQ-017 At most one load strobe SHALL be high per cycle: P1->load_pcard1, D1->load_dcard1, P2->load_pcard2, D2->load_dcard2, P3->load_pcard3, D3->load_dcard3.
REQ-018 IDLE/DONE with start=1 SHALL zero all tallies and hand_num and go to P1 next cycle; start is ignored while busy.
REQ-019 P1->D1->P2->D2->EVAL unconditionally, one cycle each.
REQ-020 EVAL: pscore>=8 or dscore>=8 -> RESULT; else pscore<=5 -> P3; else dscore<=5 -> D3; else RESULT.
REQ-021 P3 SHALL always go to D3DEC.
REQ-022 D3DEC goes to D3 when: dscore 0-2; dscore 3 and pcard3!=8; dscore 4 and pcard3 in 2..7; dscore 5 and pcard3 in 4..7; dscore 6 and pcard3 in 6..7. Otherwise it goes to RESULT.
REQ-023 D3 SHALL go to RESULT.
REQ-024 RESULT SHALL compare scores and register the outcome:
- p>d: player flag, player_wins+1.
- d>p: dealer flag, dealer_wins+1.
- equal: both flags, ties+1.
REQ-025 HOLD SHALL last exactly HOLD_CYCLES cycles with lights equal to the registered flags; the lights SHALL be 0 in all other states except DONE.
REQ-026 CLEAR SHALL assert clear_hand for one cycle and increment hand_num. The next state is DONE if the new hand_num equals ROUNDS, else P1.
REQ-027 In DONE the lights SHALL show the match outcome: player_wins>dealer_wins -> player only; dealer_wins>player_wins -> dealer only; equal -> both.
REQ-028 Tallies and hand_num SHALL hold their values in DONE until the next start.
REQ-029 Scores >9 SHALL be treated as their numeric value; there is no saturation or checking.
REQ-030 All outputs SHALL be registered or decoded from registered state only; no combinational path from any input to the load strobes.

Reset
REQ-031 resetb=0 SHALL immediately force IDLE and zero every output and counter, including mid-hand; operation resumes only on start after release.

Verification
REQ-032 Natural hand, ROUNDS=1, HOLD_CYCLES=2: start; EVAL sees p=8, d=3 -> strobes P1,D1,P2,D2 on cycles 1-4; no P3/D3; player_win_light for 2 cycles; clear_hand; DONE with player_wins=1, player light only.
REQ-033 Player draws, banker 3: p=4, d=3, pcard3=8 -> load_pcard3 once, no load_dcard3. Repeat with pcard3=7 -> load_dcard3 once.
REQ-034 Player stands: p=6, d=5 -> load_dcard3 with no load_pcard3. With p=7, d=6 -> no third cards; dealer tally unchanged; RESULT reads p=7, d=6 -> player wins.
REQ-035 Tie match, ROUNDS=2: both hands p=d=6 -> ties=2, both lights in HOLD and DONE, hand_num=2.
REQ-036 resetb pulsed low during P3 -> all outputs 0 immediately. start held high throughout a hand is ignored until DONE; start in DONE restarts with counters at 0.
